// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM (fetch/decode/execute/writeback sequencing)
module mips_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_BNE     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_NONE  = 2'd3;

    logic [3:0] state_q, state_d;
    logic [1:0] aluop;
    logic [2:0] funct_ctl;
    logic       funct_ok;
    logic       op_ok;
    logic       pcen_raw;
    logic       irwrite_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        op_ok = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: op_ok = 1'b1;
            default:                                              op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Only pcen (FETCH/BEQ/BNE) and irwrite (FETCH) look at inputs; all else is Moore.
    always_comb begin
        pcen_raw    = 1'b0;
        irwrite_raw = 1'b0;
        memwrite    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_NONE;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                aluop       = ALUOP_ADD;
                pcen_raw    = memready;
                irwrite_raw = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQ, S_BNE: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = 2'b01;
                pcen_raw = (state_q == S_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pcsrc    = 2'b10;
                pcen_raw = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_ctl = 3'b010;
        case (funct)
            6'b100000: funct_ctl = 3'b010;
            6'b100010: funct_ctl = 3'b110;
            6'b100100: funct_ctl = 3'b000;
            6'b100101: funct_ctl = 3'b001;
            6'b101010: funct_ctl = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            ALUOP_ADD:   alucontrol = 3'b010;
            ALUOP_SUB:   alucontrol = 3'b110;
            ALUOP_FUNCT: alucontrol = funct_ctl;
            default:     alucontrol = 3'b000;
        endcase
    end

    // The input-dependent strobes must stay low while reset is held even if memready is high.
    assign pcen    = pcen_raw & reset;
    assign irwrite = irwrite_raw & reset;
    assign illegal = ((state_q == S_DECODE) & ~op_ok) | ((state_q == S_RTYPEEX) & ~funct_ok);
    assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed scoreboard bench for mips_mc_controller
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [19:0] exp_q[$];
    string       tag_q[$];
    logic [19:0] obs;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
        .state(state)
    );

    assign obs = {state, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol, illegal};

    // {state, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal}
    function automatic logic [19:0] fv(input logic [3:0] st, input logic pc, mw, ir, rw, asa, io, mtr, rd,
                                       input logic [1:0] asb, ps, input logic [2:0] ac, input logic il);
        return {st, pc, mw, ir, rw, asa, io, mtr, rd, asb, ps, ac, il};
    endfunction

    task automatic push(input string t, input logic [19:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic chk();
        string       t;
        logic [19:0] e;
        total_cnt = total_cnt + 1;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) pass_cnt = pass_cnt + 1;
            else $error("FAIL %s: observed %h required %h", t, obs, e);
        end
    endtask

    task automatic cyc(input string t, input logic [19:0] e);
        push(t, e);
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] F_WAIT, F_GO, D_OK, MADR, MRD, MWB, MWR, ALUWB;

    initial begin
        F_WAIT = fv(4'd0, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        F_GO   = fv(4'd0, 1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
        D_OK   = fv(4'd1, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
        MADR   = fv(4'd2, 0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b010, 0);
        MRD    = fv(4'd3, 0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
        MWB    = fv(4'd4, 0,0,0,1,0,0,1,0, 2'b00, 2'b00, 3'b000, 0);
        MWR    = fv(4'd5, 0,1,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
        ALUWB  = fv(4'd7, 0,0,0,1,0,0,0,1, 2'b00, 2'b00, 3'b000, 0);

        reset = 1'b0; memready = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
        #2;
        push("reset_state", F_WAIT);
        chk();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // lw, memready high
        op = 6'b100011;
        cyc("lw_fetch", F_GO);
        cyc("lw_decode", D_OK);
        cyc("lw_memadr", MADR);
        cyc("lw_memrd", MRD);
        cyc("lw_memwb", MWB);

        // sw, memready low for three MEMWR cycles
        op = 6'b101011;
        cyc("sw_fetch", F_GO);
        cyc("sw_decode", D_OK);
        memready = 1'b0;
        cyc("sw_memadr", MADR);
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", MWR);
        memready = 1'b1;
        cyc("sw_memwr_done", MWR);

        // beq / bne with both zero values
        op = 6'b000100; zero = 1'b1;
        cyc("beq_fetch", F_GO);
        cyc("beq_decode", D_OK);
        cyc("beq_taken", fv(4'd8, 1,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
        zero = 1'b0;
        cyc("beq2_fetch", F_GO);
        cyc("beq2_decode", D_OK);
        cyc("beq_not_taken", fv(4'd8, 0,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
        op = 6'b000101; zero = 1'b1;
        cyc("bne_fetch", F_GO);
        cyc("bne_decode", D_OK);
        cyc("bne_not_taken", fv(4'd12, 0,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
        zero = 1'b0;
        cyc("bne2_fetch", F_GO);
        cyc("bne2_decode", D_OK);
        cyc("bne_taken", fv(4'd12, 1,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0));

        // R-type slt, then unknown funct
        op = 6'b000000; funct = 6'b101010;
        cyc("slt_fetch", F_GO);
        cyc("slt_decode", D_OK);
        cyc("slt_rtypeex", fv(4'd6, 0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b111, 0));
        cyc("slt_aluwb", ALUWB);
        funct = 6'b111111;
        cyc("badfn_fetch", F_GO);
        cyc("badfn_decode", D_OK);
        cyc("badfn_rtypeex", fv(4'd6, 0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 1));
        cyc("badfn_aluwb", ALUWB);

        // addi and j
        op = 6'b001000;
        cyc("addi_fetch", F_GO);
        cyc("addi_decode", D_OK);
        cyc("addi_ex", fv(4'd9, 0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b010, 0));
        cyc("addi_wb", fv(4'd10, 0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        op = 6'b000010;
        cyc("j_fetch", F_GO);
        cyc("j_decode", D_OK);
        cyc("j_jump", fv(4'd11, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0));

        // illegal opcode
        op = 6'b111111;
        cyc("illop_fetch", F_GO);
        cyc("illop_decode", fv(4'd1, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1));
        memready = 1'b0;
        cyc("illop_back_fetch", F_WAIT);

        // reset asserted while stalled in MEMRD
        op = 6'b100011; memready = 1'b1;
        cyc("rst_lw_fetch", F_GO);
        cyc("rst_lw_decode", D_OK);
        memready = 1'b0;
        cyc("rst_lw_memadr", MADR);
        cyc("rst_lw_memrd", MRD);
        memready = 1'b1;
        reset = 1'b0;
        #1;
        push("async_reset_in_memrd", F_WAIT);
        chk();
        @(posedge clk); #1;
        push("reset_held_over_edge", F_WAIT);
        chk();
        reset = 1'b1; memready = 1'b0;
        cyc("post_rst_wait1", F_WAIT);
        cyc("post_rst_wait2", F_WAIT);
        memready = 1'b1; op = 6'b000010;
        cyc("post_rst_fetch", F_GO);
        cyc("post_rst_decode", D_OK);
        cyc("post_rst_jump", fv(4'd11, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0));
        cyc("final_fetch", F_GO);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
